// File: rtl/sterownik_stosu_pkg.sv
// Shared types for the stack command controller: operation codes, FSM states
// and the PC-width-to-word-count helper.
package stos_pkg;

  typedef enum logic [1:0] {
    PUSH = 2'b00,
    POP  = 2'b01,
    CALL = 2'b10,
    RET  = 2'b11
  } stos_op_t;

  typedef enum logic [1:0] {
    IDLE,
    PUSH_SEQ,
    POP_SEQ,
    RESP
  } stos_state_t;

  // Number of stack words needed to hold one program counter.
  function automatic int stos_bytes(input int pc_w, input int data_w);
    return pc_w / data_w;
  endfunction

endpackage

// File: rtl/sterownik_stosu_if.sv
// Command/response channel between the instruction decoder (master) and the
// stack controller (slave).
interface sterownik_stosu_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 16
);
  import stos_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  stos_op_t          cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [PC_W-1:0]   cmd_pc;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [PC_W-1:0]   rsp_pc;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_pc,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data, rsp_pc
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_pc,
    output cmd_ready, rsp_valid, rsp_err, rsp_data, rsp_pc
  );

endinterface

// File: rtl/sterownik_stosu.sv
// Stack command controller: turns PUSH/POP/CALL/RET into single-cycle push/pop
// strobes and tracks occupancy to reject overflow/underflow up front.
module sterownik_stosu
  import stos_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 16,
  parameter int DEPTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  sterownik_stosu_if.slave             ctl,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         st_push,
  output logic                         st_pop,
  output logic [DATA_W-1:0]            st_wdata,
  input  logic [DATA_W-1:0]            st_rdata,
  input  logic                         st_full,
  input  logic                         st_empty
);

  localparam int BYTES = stos_bytes(PC_W, DATA_W);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  stos_state_t       state_reg, state_next;
  stos_op_t          op_reg, op_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [PC_W-1:0]   pc_reg, pc_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [OCC_W-1:0]  occ_reg, occ_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
  logic [PC_W-1:0]   rsp_pc_reg, rsp_pc_next;

  logic              accept_ok;
  logic              last_word;
  logic [PC_W-1:0]   pc_assembled;
  int                n_words;
  int                wr_pos;
  int                rd_pos;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      op_reg       <= PUSH;
      data_reg     <= '0;
      pc_reg       <= '0;
      idx_reg      <= '0;
      occ_reg      <= '0;
      err_reg      <= 1'b0;
      rsp_data_reg <= '0;
      rsp_pc_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      data_reg     <= data_next;
      pc_reg       <= pc_next;
      idx_reg      <= idx_next;
      occ_reg      <= occ_next;
      err_reg      <= err_next;
      rsp_data_reg <= rsp_data_next;
      rsp_pc_reg   <= rsp_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    data_next     = data_reg;
    pc_next       = pc_reg;
    idx_next      = idx_reg;
    occ_next      = occ_reg;
    err_next      = err_reg;
    rsp_data_next = rsp_data_reg;
    rsp_pc_next   = rsp_pc_reg;
    st_push       = 1'b0;
    st_pop        = 1'b0;
    st_wdata      = '0;
    accept_ok     = 1'b0;
    n_words       = ((op_reg == PUSH) || (op_reg == POP)) ? 1 : BYTES;
    last_word     = (idx_reg == IDX_W'(n_words - 1));
    wr_pos        = int'(idx_reg) * DATA_W;
    // RET rebuilds the PC most-significant word first.
    rd_pos        = (BYTES - 1 - int'(idx_reg)) * DATA_W;
    pc_assembled  = pc_reg;
    pc_assembled[rd_pos +: DATA_W] = st_rdata;

    case (state_reg)
      IDLE: begin
        if (ctl.cmd_valid) begin
          op_next   = ctl.cmd_op;
          data_next = ctl.cmd_data;
          pc_next   = ctl.cmd_pc;
          idx_next  = '0;
          case (ctl.cmd_op)
            PUSH: accept_ok = (int'(occ_reg) <= DEPTH - 1);
            CALL: accept_ok = (int'(occ_reg) <= DEPTH - BYTES);
            POP:  accept_ok = (int'(occ_reg) >= 1);
            RET:  accept_ok = (int'(occ_reg) >= BYTES);
          endcase
          err_next = !accept_ok;
          if (!accept_ok)
            state_next = RESP;
          else if ((ctl.cmd_op == PUSH) || (ctl.cmd_op == CALL))
            state_next = PUSH_SEQ;
          else
            state_next = POP_SEQ;
        end
      end
      PUSH_SEQ: begin
        st_push  = 1'b1;
        st_wdata = (op_reg == PUSH) ? data_reg : pc_reg[wr_pos +: DATA_W];
        occ_next = occ_reg + OCC_W'(1);
        idx_next = idx_reg + IDX_W'(1);
        if (last_word)
          state_next = RESP;
      end
      POP_SEQ: begin
        st_pop   = 1'b1;
        occ_next = occ_reg - OCC_W'(1);
        idx_next = idx_reg + IDX_W'(1);
        if (op_reg == RET)
          pc_next = pc_assembled;
        if (last_word) begin
          state_next = RESP;
          if (op_reg == POP)
            rsp_data_next = st_rdata;
          else
            rsp_pc_next = pc_assembled;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ctl.cmd_ready = (state_reg == IDLE);
  assign ctl.rsp_valid = (state_reg == RESP);
  assign ctl.rsp_err   = err_reg;
  assign ctl.rsp_data  = rsp_data_reg;
  assign ctl.rsp_pc    = rsp_pc_reg;
  assign occupancy     = occ_reg;

  // The local count must track the stack's own flags exactly.
  a_full_matches:  assert property (@(posedge clk) disable iff (!rst)
                                    st_full == (occ_reg == OCC_W'(DEPTH)));
  a_empty_matches: assert property (@(posedge clk) disable iff (!rst)
                                    st_empty == (occ_reg == '0));

endmodule
